fx1_pipe_unit: RTL and testbench

- Pipelined successor to the combinational simple-fixed-point execution datapath in the SPU even pipe.
- Accepts one FX1-class instruction per cycle and computes the result in stage 1.
- Carries the result, target register and valid bit through LATENCY register stages, with stall, flush and per-stage forwarding taps.
- Sits between the register-file read/forward mux and the even-pipe writeback arbiter.

---
 rtl/fx1_pipe_unit.sv | 211 +++++++++++++++++++++
 tb/tb_fx1_pipe_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx1_pipe_unit.sv
// Pipelined FX1 simple-fixed-point execution unit for the SPU even pipe.
// Stage 1 computes the result; LATENCY register stages carry it to writeback.
module fx1_pipe_unit #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned RT_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [6:0]                instr_id,
    input  logic [DATA_W-1:0]         ra_data,
    input  logic [DATA_W-1:0]         rb_data,
    input  logic [DATA_W-1:0]         rc_data,
    input  logic [9:0]                imme10,
    input  logic [15:0]               imme16,
    input  logic [17:0]               imme18,
    input  logic [RT_W-1:0]           rt_addr,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [RT_W-1:0]           out_rt,
    output logic [DATA_W-1:0]         out_result,
    output logic [LATENCY-1:0]        fwd_valid,
    output logic [LATENCY*RT_W-1:0]   fwd_rt,
    output logic [LATENCY*DATA_W-1:0] fwd_data,
    output logic                      busy
);

    // instr_ID values shared with the opcode package
    localparam logic [6:0] ID_A     = 7'd0;
    localparam logic [6:0] ID_AH    = 7'd1;
    localparam logic [6:0] ID_AI    = 7'd2;
    localparam logic [6:0] ID_AHI   = 7'd3;
    localparam logic [6:0] ID_SF    = 7'd4;
    localparam logic [6:0] ID_SFH   = 7'd5;
    localparam logic [6:0] ID_SFI   = 7'd6;
    localparam logic [6:0] ID_SFHI  = 7'd7;
    localparam logic [6:0] ID_ADDX  = 7'd8;
    localparam logic [6:0] ID_SFX   = 7'd9;
    localparam logic [6:0] ID_CG    = 7'd10;
    localparam logic [6:0] ID_CGX   = 7'd11;
    localparam logic [6:0] ID_BG    = 7'd12;
    localparam logic [6:0] ID_BGX   = 7'd13;
    localparam logic [6:0] ID_AND   = 7'd14;
    localparam logic [6:0] ID_ANDI  = 7'd15;
    localparam logic [6:0] ID_ANDHI = 7'd16;
    localparam logic [6:0] ID_OR    = 7'd17;
    localparam logic [6:0] ID_ORI   = 7'd18;
    localparam logic [6:0] ID_ORHI  = 7'd19;
    localparam logic [6:0] ID_XOR   = 7'd20;
    localparam logic [6:0] ID_XORI  = 7'd21;
    localparam logic [6:0] ID_XORHI = 7'd22;
    localparam logic [6:0] ID_NAND  = 7'd23;
    localparam logic [6:0] ID_NOR   = 7'd24;
    localparam logic [6:0] ID_EQV   = 7'd25;
    localparam logic [6:0] ID_SELB  = 7'd26;
    localparam logic [6:0] ID_CEQ   = 7'd27;
    localparam logic [6:0] ID_CEQH  = 7'd28;
    localparam logic [6:0] ID_CEQI  = 7'd29;
    localparam logic [6:0] ID_CEQHI = 7'd30;
    localparam logic [6:0] ID_CGT   = 7'd31;
    localparam logic [6:0] ID_CGTH  = 7'd32;
    localparam logic [6:0] ID_CGTI  = 7'd33;
    localparam logic [6:0] ID_CGTHI = 7'd34;
    localparam logic [6:0] ID_CLZ   = 7'd35;
    localparam logic [6:0] ID_IL    = 7'd36;
    localparam logic [6:0] ID_ILH   = 7'd37;
    localparam logic [6:0] ID_ILHU  = 7'd38;
    localparam logic [6:0] ID_ILA   = 7'd39;
    localparam logic [6:0] ID_IOHL  = 7'd40;

    localparam int unsigned NW = DATA_W / 32;
    localparam int unsigned NH = DATA_W / 16;

    function automatic logic [31:0] clz32(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd32;
        for (int unsigned i = 0; i < 32; i++)
            if (v[i]) n = 32'(31 - i);
        return n;
    endfunction

    logic [DATA_W-1:0] result;
    logic [31:0]       imm_w;
    logic [15:0]       imm_h;

    assign imm_w = {{22{imme10[9]}}, imme10};
    assign imm_h = {{6{imme10[9]}}, imme10};

    // Word slots are written first; halfword ops then overwrite the whole vector.
    always_comb begin
        logic [31:0] a_w, b_w, c_w, r_w;
        logic [32:0] sum_w;
        logic [15:0] a_h, b_h, r_h;
        logic        h_hit;
        result = '0;
        for (int unsigned w = 0; w < NW; w++) begin
            a_w   = ra_data[w*32 +: 32];
            b_w   = rb_data[w*32 +: 32];
            c_w   = rc_data[w*32 +: 32];
            sum_w = '0;
            r_w   = '0;
            case (instr_id)
                ID_A:    r_w = a_w + b_w;
                ID_AI:   r_w = a_w + imm_w;
                ID_SF:   r_w = b_w - a_w;
                ID_SFI:  r_w = imm_w - a_w;
                ID_ADDX: r_w = a_w + b_w + {31'b0, c_w[0]};
                ID_SFX:  r_w = b_w + ~a_w + {31'b0, c_w[0]};
                ID_CG: begin
                    sum_w = {1'b0, a_w} + {1'b0, b_w};
                    r_w   = {31'b0, sum_w[32]};
                end
                ID_CGX: begin
                    sum_w = {1'b0, a_w} + {1'b0, b_w} + {32'b0, c_w[0]};
                    r_w   = {31'b0, sum_w[32]};
                end
                ID_BG:   r_w = {31'b0, b_w >= a_w};
                ID_BGX: begin
                    // carry out of rb + ~ra + cin is the "no borrow" flag
                    sum_w = {1'b0, b_w} + {1'b0, ~a_w} + {32'b0, c_w[0]};
                    r_w   = {31'b0, sum_w[32]};
                end
                ID_AND:  r_w = a_w & b_w;
                ID_ANDI: r_w = a_w & imm_w;
                ID_OR:   r_w = a_w | b_w;
                ID_ORI:  r_w = a_w | imm_w;
                ID_XOR:  r_w = a_w ^ b_w;
                ID_XORI: r_w = a_w ^ imm_w;
                ID_NAND: r_w = ~(a_w & b_w);
                ID_NOR:  r_w = ~(a_w | b_w);
                ID_EQV:  r_w = ~(a_w ^ b_w);
                ID_SELB: r_w = (c_w & b_w) | (~c_w & a_w);
                ID_CEQ:  r_w = {32{a_w == b_w}};
                ID_CEQI: r_w = {32{a_w == imm_w}};
                ID_CGT:  r_w = {32{$signed(a_w) > $signed(b_w)}};
                ID_CGTI: r_w = {32{$signed(a_w) > $signed(imm_w)}};
                ID_CLZ:  r_w = clz32(a_w);
                ID_IL:   r_w = {{16{imme16[15]}}, imme16};
                ID_ILHU: r_w = {imme16, 16'h0000};
                ID_ILA:  r_w = {14'b0, imme18};
                ID_IOHL: r_w = c_w | {16'h0000, imme16};
                default: r_w = '0;
            endcase
            result[w*32 +: 32] = r_w;
        end
        for (int unsigned h = 0; h < NH; h++) begin
            a_h   = ra_data[h*16 +: 16];
            b_h   = rb_data[h*16 +: 16];
            r_h   = '0;
            h_hit = 1'b1;
            case (instr_id)
                ID_AH:    r_h = a_h + b_h;
                ID_AHI:   r_h = a_h + imm_h;
                ID_SFH:   r_h = b_h - a_h;
                ID_SFHI:  r_h = imm_h - a_h;
                ID_ANDHI: r_h = a_h & imm_h;
                ID_ORHI:  r_h = a_h | imm_h;
                ID_XORHI: r_h = a_h ^ imm_h;
                ID_CEQH:  r_h = {16{a_h == b_h}};
                ID_CEQHI: r_h = {16{a_h == imm_h}};
                ID_CGTH:  r_h = {16{$signed(a_h) > $signed(b_h)}};
                ID_CGTHI: r_h = {16{$signed(a_h) > $signed(imm_h)}};
                ID_ILH:   r_h = imme16;
                default:  h_hit = 1'b0;
            endcase
            if (h_hit) result[h*16 +: 16] = r_h;
        end
    end

    logic [LATENCY-1:0] st_valid;
    logic [RT_W-1:0]    st_rt   [LATENCY];
    logic [DATA_W-1:0]  st_data [LATENCY];

    // Flush only clears valids; stale data behind a cleared valid is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                st_rt[k]   <= '0;
                st_data[k] <= '0;
            end
        end else if (flush) begin
            st_valid <= '0;
        end else if (!stall) begin
            st_valid[0] <= in_valid;
            if (in_valid) begin
                st_rt[0]   <= rt_addr;
                st_data[0] <= result;
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_rt[k]    <= st_rt[k-1];
                st_data[k]  <= st_data[k-1];
            end
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_fwd
        assign fwd_rt[k*RT_W +: RT_W]       = st_rt[k];
        assign fwd_data[k*DATA_W +: DATA_W] = st_data[k];
    end

    assign fwd_valid  = st_valid;
    assign out_valid  = st_valid[LATENCY-1];
    assign out_rt     = st_rt[LATENCY-1];
    assign out_result = st_data[LATENCY-1];
    assign busy       = |st_valid;

endmodule

// File: tb/tb_fx1_pipe_unit.sv
// Randomized self-checking bench for fx1_pipe_unit at LATENCY 1, 2, 3 and 7,
// checked against an age-based model of in-flight instructions.
module tb_fx1_pipe_unit;

    localparam logic [6:0] ID_A = 7'd0, ID_AH = 7'd1, ID_AI = 7'd2, ID_AHI = 7'd3;
    localparam logic [6:0] ID_SF = 7'd4, ID_SFH = 7'd5, ID_SFI = 7'd6, ID_SFHI = 7'd7;
    localparam logic [6:0] ID_ADDX = 7'd8, ID_SFX = 7'd9, ID_CG = 7'd10, ID_CGX = 7'd11;
    localparam logic [6:0] ID_BG = 7'd12, ID_BGX = 7'd13, ID_AND = 7'd14, ID_ANDI = 7'd15;
    localparam logic [6:0] ID_ANDHI = 7'd16, ID_OR = 7'd17, ID_ORI = 7'd18, ID_ORHI = 7'd19;
    localparam logic [6:0] ID_XOR = 7'd20, ID_XORI = 7'd21, ID_XORHI = 7'd22, ID_NAND = 7'd23;
    localparam logic [6:0] ID_NOR = 7'd24, ID_EQV = 7'd25, ID_SELB = 7'd26, ID_CEQ = 7'd27;
    localparam logic [6:0] ID_CEQH = 7'd28, ID_CEQI = 7'd29, ID_CEQHI = 7'd30, ID_CGT = 7'd31;
    localparam logic [6:0] ID_CGTH = 7'd32, ID_CGTI = 7'd33, ID_CGTHI = 7'd34, ID_CLZ = 7'd35;
    localparam logic [6:0] ID_IL = 7'd36, ID_ILH = 7'd37, ID_ILHU = 7'd38, ID_ILA = 7'd39;
    localparam logic [6:0] ID_IOHL = 7'd40;

    logic         clk = 1'b0;
    logic         rst, in_valid, stall, flush;
    logic [6:0]   instr_id, rt_addr;
    logic [127:0] ra_data, rb_data, rc_data;
    logic [9:0]   imme10;
    logic [15:0]  imme16;
    logic [17:0]  imme18;

    logic ov1, ov2, ov3, ov7, busy1, busy2, busy3, busy7;
    logic [6:0]   ort1, ort2, ort3, ort7;
    logic [127:0] ores1, ores2, ores3, ores7;
    logic [0:0]   fv1;
    logic [1:0]   fv2;
    logic [2:0]   fv3;
    logic [6:0]   fv7;
    logic [6:0]   frt1;
    logic [13:0]  frt2;
    logic [20:0]  frt3;
    logic [48:0]  frt7;
    logic [127:0] fd1;
    logic [255:0] fd2;
    logic [383:0] fd3;
    logic [895:0] fd7;

    always #5 clk = ~clk;

    fx1_pipe_unit #(.DATA_W(128), .LATENCY(1), .RT_W(7)) u_lat1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_id(instr_id),
        .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
        .imme10(imme10), .imme16(imme16), .imme18(imme18), .rt_addr(rt_addr),
        .stall(stall), .flush(flush), .out_valid(ov1), .out_rt(ort1), .out_result(ores1),
        .fwd_valid(fv1), .fwd_rt(frt1), .fwd_data(fd1), .busy(busy1));
    fx1_pipe_unit #(.DATA_W(128), .LATENCY(2), .RT_W(7)) u_lat2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_id(instr_id),
        .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
        .imme10(imme10), .imme16(imme16), .imme18(imme18), .rt_addr(rt_addr),
        .stall(stall), .flush(flush), .out_valid(ov2), .out_rt(ort2), .out_result(ores2),
        .fwd_valid(fv2), .fwd_rt(frt2), .fwd_data(fd2), .busy(busy2));
    fx1_pipe_unit #(.DATA_W(128), .LATENCY(3), .RT_W(7)) u_lat3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_id(instr_id),
        .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
        .imme10(imme10), .imme16(imme16), .imme18(imme18), .rt_addr(rt_addr),
        .stall(stall), .flush(flush), .out_valid(ov3), .out_rt(ort3), .out_result(ores3),
        .fwd_valid(fv3), .fwd_rt(frt3), .fwd_data(fd3), .busy(busy3));
    fx1_pipe_unit #(.DATA_W(128), .LATENCY(7), .RT_W(7)) u_lat7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_id(instr_id),
        .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
        .imme10(imme10), .imme16(imme16), .imme18(imme18), .rt_addr(rt_addr),
        .stall(stall), .flush(flush), .out_valid(ov7), .out_rt(ort7), .out_result(ores7),
        .fwd_valid(fv7), .fwd_rt(frt7), .fwd_data(fd7), .busy(busy7));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference result from the instruction definitions, slot by slot in plain arithmetic.
    function automatic logic [127:0] ref_op(input logic [6:0] id, input logic [127:0] ra,
            input logic [127:0] rb, input logic [127:0] rc, input logic [9:0] i10,
            input logic [15:0] i16, input logic [17:0] i18);
        logic [127:0] r;
        longint s10, s16, a, b, c, sa, sb, v;
        bit hit;
        r   = '0;
        s10 = i10[9] ? longint'(i10) - 1024 : longint'(i10);
        s16 = i16[15] ? longint'(i16) - 65536 : longint'(i16);
        for (int w = 0; w < 4; w++) begin
            a = longint'(ra[w*32 +: 32]);
            b = longint'(rb[w*32 +: 32]);
            c = longint'(rc[w*32 +: 32]);
            sa = (a >= 64'sh80000000) ? a - 64'sh100000000 : a;
            sb = (b >= 64'sh80000000) ? b - 64'sh100000000 : b;
            v = 0;
            hit = 1;
            case (id)
                ID_A:    v = a + b;
                ID_AI:   v = a + s10;
                ID_SF:   v = b - a;
                ID_SFI:  v = s10 - a;
                ID_ADDX: v = a + b + (c & 1);
                ID_SFX:  v = b - a - 1 + (c & 1);
                ID_CG:   v = (a + b) >>> 32;
                ID_CGX:  v = (a + b + (c & 1)) >>> 32;
                ID_BG:   v = (b >= a) ? 1 : 0;
                ID_BGX:  v = (b - a - 1 + (c & 1) >= 0) ? 1 : 0;
                ID_AND:  v = a & b;
                ID_ANDI: v = a & s10;
                ID_OR:   v = a | b;
                ID_ORI:  v = a | s10;
                ID_XOR:  v = a ^ b;
                ID_XORI: v = a ^ s10;
                ID_NAND: v = ~(a & b);
                ID_NOR:  v = ~(a | b);
                ID_EQV:  v = ~(a ^ b);
                ID_SELB: v = (c & b) | (~c & a);
                ID_CEQ:  v = (a == b) ? -1 : 0;
                ID_CEQI: v = (a == (s10 & 64'hFFFFFFFF)) ? -1 : 0;
                ID_CGT:  v = (sa > sb) ? -1 : 0;
                ID_CGTI: v = (sa > s10) ? -1 : 0;
                ID_CLZ:  while (v < 32 && a[31 - v] == 1'b0) v++;
                ID_IL:   v = s16;
                ID_ILHU: v = longint'(i16) * 65536;
                ID_ILA:  v = longint'(i18);
                ID_IOHL: v = c | longint'(i16);
                default: hit = 0;
            endcase
            if (hit) r[w*32 +: 32] = v[31:0];
        end
        for (int h = 0; h < 8; h++) begin
            a = longint'(ra[h*16 +: 16]);
            b = longint'(rb[h*16 +: 16]);
            sa = (a >= 32768) ? a - 65536 : a;
            sb = (b >= 32768) ? b - 65536 : b;
            v = 0;
            hit = 1;
            case (id)
                ID_AH:    v = a + b;
                ID_AHI:   v = a + s10;
                ID_SFH:   v = b - a;
                ID_SFHI:  v = s10 - a;
                ID_ANDHI: v = a & s10;
                ID_ORHI:  v = a | s10;
                ID_XORHI: v = a ^ s10;
                ID_CEQH:  v = (a == b) ? -1 : 0;
                ID_CEQHI: v = (a == (s10 & 64'hFFFF)) ? -1 : 0;
                ID_CGTH:  v = (sa > sb) ? -1 : 0;
                ID_CGTHI: v = (sa > s10) ? -1 : 0;
                ID_ILH:   v = longint'(i16);
                default:  hit = 0;
            endcase
            if (hit) r[h*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    // Accepted instructions, oldest first; age = advancing edges seen since issue, counting the issue edge.
    typedef struct {
        int           adv_at;
        logic [6:0]   rt;
        logic [127:0] data;
    } entry_t;
    entry_t q[$];
    int adv = 0;
    bit was_reset = 0;

    task automatic model_edge();
        entry_t e;
        if (rst) begin
            q.delete();
            was_reset = 1;
        end else begin
            was_reset = 0;
            if (flush) q.delete();
            else if (!stall) begin
                adv++;
                if (in_valid) begin
                    e.adv_at = adv;
                    e.rt     = rt_addr;
                    e.data   = ref_op(instr_id, ra_data, rb_data, rc_data, imme10, imme16, imme18);
                    q.push_back(e);
                end
                while (q.size() > 0 && adv - q[0].adv_at + 1 > 7) void'(q.pop_front());
            end
        end
    endtask

    task automatic check_dut(input int lat, input logic ov, input logic [6:0] ort,
            input logic [127:0] ores, input logic [6:0] fv, input logic [48:0] frt,
            input logic [895:0] fd, input logic bz);
        logic [6:0]   efv;
        logic [6:0]   ert [7];
        logic [127:0] ed  [7];
        int age;
        efv = '0;
        for (int k = 0; k < 7; k++) begin
            ert[k] = '0;
            ed[k]  = '0;
        end
        foreach (q[i]) begin
            age = adv - q[i].adv_at + 1;
            if (age >= 1 && age <= lat) begin
                efv[age-1] = 1'b1;
                ert[age-1] = q[i].rt;
                ed[age-1]  = q[i].data;
            end
        end
        check_eq($sformatf("L%0d fwd_valid", lat), 128'(fv), 128'(efv));
        check_eq($sformatf("L%0d out_valid", lat), 128'(ov), 128'(efv[lat-1]));
        check_eq($sformatf("L%0d busy", lat), 128'(bz), 128'(|efv));
        if (efv[lat-1]) begin
            check_eq($sformatf("L%0d out_rt", lat), 128'(ort), 128'(ert[lat-1]));
            check_eq($sformatf("L%0d out_result", lat), ores, ed[lat-1]);
        end
        for (int k = 0; k < lat; k++) begin
            if (efv[k]) begin
                check_eq($sformatf("L%0d fwd_rt[%0d]", lat, k), 128'(frt[k*7 +: 7]), 128'(ert[k]));
                check_eq($sformatf("L%0d fwd_data[%0d]", lat, k), fd[k*128 +: 128], ed[k]);
            end
            if (was_reset) begin
                check_eq($sformatf("L%0d reset fwd_rt[%0d]", lat, k), 128'(frt[k*7 +: 7]), '0);
                check_eq($sformatf("L%0d reset fwd_data[%0d]", lat, k), fd[k*128 +: 128], '0);
            end
        end
        if (was_reset) begin
            check_eq($sformatf("L%0d reset out_rt", lat), 128'(ort), '0);
            check_eq($sformatf("L%0d reset out_result", lat), ores, '0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_dut(1, ov1, ort1, ores1, 7'(fv1), 49'(frt1), 896'(fd1), busy1);
        check_dut(2, ov2, ort2, ores2, 7'(fv2), 49'(frt2), 896'(fd2), busy2);
        check_dut(3, ov3, ort3, ores3, 7'(fv3), 49'(frt3), 896'(fd3), busy3);
        check_dut(7, ov7, ort7, ores7, fv7, frt7, fd7, busy7);
    endtask

    task automatic issue(input logic [6:0] id, input logic [127:0] a, input logic [127:0] b,
            input logic [127:0] c, input logic [9:0] i10, input logic [15:0] i16,
            input logic [17:0] i18, input logic [6:0] rt);
        in_valid = 1'b1;
        instr_id = id;
        ra_data  = a;
        rb_data  = b;
        rc_data  = c;
        imme10   = i10;
        imme16   = i16;
        imme18   = i18;
        rt_addr  = rt;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(4))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h1 << $urandom_range(31);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rand_vec();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr_id = '0; rt_addr = '0; ra_data = '0; rb_data = '0; rc_data = '0;
        imme10 = '0; imme16 = '0; imme18 = '0;
        #2;
        idle(2);
        rst = 1'b0;

        // add words, LATENCY=2 writeback two edges after issue
        issue(ID_A, {4{32'h1}}, {4{32'h1}}, '0, '0, '0, '0, 7'd5);
        idle(1);
        check_eq("a out_valid", 128'(ov2), 128'(1));
        check_eq("a out_rt", 128'(ort2), 128'(5));
        check_eq("a result", ores2, {4{32'h2}});
        idle(1);
        check_eq("a busy drained", 128'(busy2), 128'(0));

        // back-to-back ah wrap then cgx carry
        issue(ID_AH, {8{16'hFFFF}}, {8{16'h0001}}, '0, '0, '0, '0, 7'd6);
        issue(ID_CGX, {4{32'hFFFFFFFF}}, '0, {4{32'h1}}, '0, '0, '0, 7'd7);
        check_eq("ah out_valid", 128'(ov2), 128'(1));
        check_eq("ah wrap", ores2, '0);
        idle(1);
        check_eq("cgx out_valid", 128'(ov2), 128'(1));
        check_eq("cgx carry", ores2, {4{32'h1}});
        idle(2);

        // ceqi held by stall
        issue(ID_CEQI, {4{32'hFFFFFFFD}}, '0, '0, 10'h3FD, '0, '0, 7'd9);
        stall = 1'b1;
        idle(3);
        check_eq("stall hold L1 out_valid", 128'(ov1), 128'(1));
        check_eq("stall hold L2 out_valid", 128'(ov2), 128'(0));
        stall = 1'b0;
        idle(1);
        check_eq("ceqi out_valid", 128'(ov2), 128'(1));
        check_eq("ceqi result", ores2, {128{1'b1}});
        idle(7);

        // flush kills everything including the same-cycle issue
        issue(ID_OR, rand_vec(), rand_vec(), '0, '0, '0, '0, 7'd1);
        issue(ID_XOR, rand_vec(), rand_vec(), '0, '0, '0, '0, 7'd2);
        flush = 1'b1;
        issue(ID_SF, rand_vec(), rand_vec(), '0, '0, '0, '0, 7'd3);
        flush = 1'b0;
        check_eq("flush fwd_valid", 128'(fv3), 128'(0));
        check_eq("flush busy", 128'(busy3), 128'(0));
        issue(ID_IL, '0, '0, '0, '0, 16'h8000, '0, 7'd4);
        idle(2);
        check_eq("il out_valid", 128'(ov3), 128'(1));
        check_eq("il result", ores3, {4{32'hFFFF8000}});
        idle(5);

        // reset mid-flight, then an unsupported ID
        issue(ID_A, rand_vec(), rand_vec(), '0, '0, '0, '0, 7'd10);
        issue(ID_SFI, rand_vec(), '0, '0, 10'h155, '0, '0, 7'd11);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("reset out_valid", 128'(ov2), 128'(0));
        check_eq("reset busy", 128'(busy7), 128'(0));
        issue(7'h7F, rand_vec(), rand_vec(), rand_vec(), '0, '0, '0, 7'd12);
        idle(1);
        check_eq("unsupported out_valid", 128'(ov2), 128'(1));
        check_eq("unsupported result", ores2, '0);
        idle(6);

        // clz boundaries at LATENCY 1 and 7
        issue(ID_CLZ, {32'h00010000, 32'h80000000, 32'h1, 32'h0}, '0, '0, '0, '0, '0, 7'd13);
        check_eq("clz L1", ores1, {32'd15, 32'd0, 32'd31, 32'd32});
        idle(6);
        check_eq("clz L7 token", 128'(fv7), 128'(7'b1000000));
        check_eq("clz L7", ores7, {32'd15, 32'd0, 32'd31, 32'd32});
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(99) < 70);
            instr_id = ($urandom_range(19) == 0) ? 7'(41 + $urandom_range(86)) : 7'($urandom_range(40));
            ra_data  = rand_vec();
            rb_data  = ($urandom_range(5) == 0) ? ra_data : rand_vec();
            rc_data  = rand_vec();
            imme10   = 10'($urandom);
            imme16   = 16'($urandom);
            imme18   = 18'($urandom);
            rt_addr  = 7'($urandom);
            stall    = ($urandom_range(99) < 15);
            flush    = ($urandom_range(99) < 4);
            rst      = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
